// File: rtl/instr_encoder.sv
// ============================================================================
// instr_encoder
// ----------------------------------------------------------------------------
// Write side of the controller's instruction format. Decoded field sets
// (class, ALU op, rd, rs, rt, imm) arrive over a valid/ready handshake. Each
// set is packed into a 32-bit word and queued in a small FIFO. Queued words
// are then written to instruction memory, one per cycle, at an address that
// increments after every write.
//
// Optional feature macro: IMM_RANGE_CHECK_EN
//   When this macro is defined, an I-type or mem immediate must fit in signed
//   14 bits (imm[14] == imm[13]). A set that fails the check is written as a
//   NOP (32'h0) and raises err. When the macro is undefined, imm[14] is
//   dropped without raising an error.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             one-cycle pulse that begins a load session (IDLE only)
//   start_addr_vld    use start_addr rather than BASE_DEFAULT
//   start_addr        first write address of the session
//   in_valid/in_ready field-set handshake; in_last marks the final set
//   cls, aluop, rd, rs, rt, imm   decoded instruction fields
//   im_we, im_addr, im_wdata      instruction-memory write port (registered)
//   busy              session in progress (state != IDLE)
//   done              one-cycle pulse after the last word is written
//   err, err_cnt      sticky reject flag / saturating reject count
// ============================================================================
module instr_encoder #(
   parameter int DEPTH        = 4,
   parameter int AW           = 8,
   parameter int BASE_DEFAULT = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          start_addr_vld,
   input  logic [AW-1:0] start_addr,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_last,
   input  logic [1:0]    cls,
   input  logic [3:0]    aluop,
   input  logic [5:0]    rd,
   input  logic [5:0]    rs,
   input  logic [5:0]    rt,
   input  logic [14:0]   imm,
   output logic          im_we,
   output logic [AW-1:0] im_addr,
   output logic [31:0]   im_wdata,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [7:0]    err_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);
   localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
   localparam logic [AW-1:0] BASE_ADDR = AW'(BASE_DEFAULT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Packs a legal field set; the class selects rt or the low 14 imm bits.
   function automatic logic [31:0] encode_fields(
      input logic [1:0]  c,
      input logic [3:0]  op,
      input logic [5:0]  d,
      input logic [5:0]  s,
      input logic [5:0]  t,
      input logic [13:0] im14
   );
      logic [31:0] w;
      case (c)
         2'b01:   w = {c, op, d, s, t, 8'h00};
         2'b00,
         2'b10:   w = {c, op, d, s, im14};
         default: w = 32'h0000_0000;
      endcase
      return w;
   endfunction

   // Saturating increment for the reject counter.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? 8'hFF : (v + 8'd1);
   endfunction

   state_t          state_q, state_d;
   logic [31:0]     fifo_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [AW-1:0]   addr_q, addr_d;

   logic            in_ready_q, in_ready_d;
   logic            im_we_q, im_we_d;
   logic [AW-1:0]   im_addr_q, im_addr_d;
   logic [31:0]     im_wdata_q, im_wdata_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic [7:0]      err_cnt_q, err_cnt_d;

   logic            fire_s;
   logic            pop_s;
   logic            bad_s;
   logic            range_bad_s;
   logic [31:0]     enc_word_s;

`ifdef IMM_RANGE_CHECK_EN
   // An immediate fits in signed 14 bits only when bit 14 repeats bit 13.
   assign range_bad_s = (cls != 2'b01) && (imm[14] != imm[13]);
`else
   logic unused_imm_s;
   assign range_bad_s  = 1'b0;
   assign unused_imm_s = imm[14];
`endif

   assign bad_s      = (cls == 2'b11) || range_bad_s;
   assign enc_word_s = bad_s ? 32'h0000_0000
                             : encode_fields(cls, aluop, rd, rs, rt, imm[13:0]);

   // Handshake uses the registered ready, so a full FIFO can never be pushed.
   assign fire_s = (state_q == S_RUN) && in_valid && in_ready_q;
   assign pop_s  = (count_q != {CW{1'b0}}) &&
                   ((state_q == S_RUN) || (state_q == S_DRAIN));

   // Next-state, FIFO bookkeeping, write path and error accounting.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      addr_d     = addr_q;
      im_we_d    = 1'b0;
      im_addr_d  = im_addr_q;
      im_wdata_d = im_wdata_q;
      err_d      = err_q;
      err_cnt_d  = err_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_RUN;
               addr_d    = start_addr_vld ? start_addr : BASE_ADDR;
               err_d     = 1'b0;
               err_cnt_d = 8'h00;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (fire_s && in_last) begin
               state_d = S_DRAIN;
            end else begin
               state_d = S_RUN;
            end
         end
         S_DRAIN: begin
            // An empty FIFO here means the final write is on the port now.
            if (count_q == {CW{1'b0}}) begin
               state_d = S_DONE;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (fire_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (bad_s) begin
            err_d     = 1'b1;
            err_cnt_d = sat_inc8(err_cnt_q);
         end else begin
            err_d     = err_q;
            err_cnt_d = err_cnt_q;
         end
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d   = rd_ptr_q + PTR_ONE;
         im_we_d    = 1'b1;
         im_addr_d  = addr_q;
         im_wdata_d = fifo_q[rd_ptr_q];
         addr_d     = addr_q + ADDR_ONE;   // wraps silently at 2^AW
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      if (fire_s && !pop_s) begin
         count_d = count_q + CNT_ONE;
      end else if (!fire_s && pop_s) begin
         count_d = count_q - CNT_ONE;
      end else begin
         count_d = count_q;
      end
   end

   // Ready drops in the same cycle the queue reaches DEPTH entries.
   assign in_ready_d = (state_d == S_RUN) && (count_d != FULL_CNT);
   assign busy_d     = (state_d != S_IDLE);
   assign done_d     = (state_d == S_DONE);

   // State and registered outputs; rst discards any in-flight words.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= {PW{1'b0}};
         rd_ptr_q   <= {PW{1'b0}};
         count_q    <= {CW{1'b0}};
         addr_q     <= {AW{1'b0}};
         in_ready_q <= 1'b0;
         im_we_q    <= 1'b0;
         im_addr_q  <= {AW{1'b0}};
         im_wdata_q <= 32'h0000_0000;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_cnt_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         addr_q     <= addr_d;
         in_ready_q <= in_ready_d;
         im_we_q    <= im_we_d;
         im_addr_q  <= im_addr_d;
         im_wdata_q <= im_wdata_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   // FIFO storage holds data only; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (fire_s) begin
         fifo_q[wr_ptr_q] <= enc_word_s;
      end
   end

   assign in_ready = in_ready_q;
   assign im_we    = im_we_q;
   assign im_addr  = im_addr_q;
   assign im_wdata = im_wdata_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        start_addr_vld;
   logic [7:0]  start_addr;
   logic        in_valid;
   logic        in_ready;
   logic        in_last;
   logic [1:0]  cls;
   logic [3:0]  aluop;
   logic [5:0]  rd;
   logic [5:0]  rs;
   logic [5:0]  rt;
   logic [14:0] imm;
   logic        im_we;
   logic [7:0]  im_addr;
   logic [31:0] im_wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [7:0]  err_cnt;

   always #5 clk = ~clk;

   instr_encoder #(.DEPTH(4), .AW(8), .BASE_DEFAULT(0)) dut (
      .clk(clk), .rst(rst), .start(start), .start_addr_vld(start_addr_vld),
      .start_addr(start_addr), .in_valid(in_valid), .in_ready(in_ready),
      .in_last(in_last), .cls(cls), .aluop(aluop), .rd(rd), .rs(rs), .rt(rt),
      .imm(imm), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
      .busy(busy), .done(done), .err(err), .err_cnt(err_cnt)
   );

   typedef struct {
      logic [1:0]  c;
      logic [3:0]  op;
      logic [5:0]  d;
      logic [5:0]  s;
      logic [5:0]  t;
      logic [14:0] im;
   } fs_t;

   typedef struct {
      fs_t         f;
      logic [31:0] exp_word;
   } vec_t;

   int checks   = 0;
   int failures = 0;

   fs_t         sess[$];
   logic [31:0] exp_q[$];
   int          exp_err;
   logic [7:0]  cap_addr[$];
   logic [31:0] cap_data[$];
   int          done_cnt;

   // Record every memory write and done pulse, well clear of the clock edge.
   always @(posedge clk) begin
      #2;
      if (im_we) begin
         cap_addr.push_back(im_addr);
         cap_data.push_back(im_wdata);
      end
      if (done) done_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference rules: a class-11 set, or (with range check) an out-of-range imm.
   function automatic bit model_bad(input fs_t f);
      int unsigned iv;
      iv = f.im;
      if (f.c == 2'd3) return 1'b1;
`ifdef IMM_RANGE_CHECK_EN
      if (f.c != 2'd1 && iv >= 32'd8192 && iv < 32'd24576) return 1'b1;
`endif
      if (iv > 32'd32767) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_word(input fs_t f);
      longint unsigned w;
      if (model_bad(f)) return 32'h0;
      w = 64'(f.c) * 64'd1073741824 + 64'(f.op) * 64'd67108864
        + 64'(f.d) * 64'd1048576 + 64'(f.s) * 64'd16384;
      if (f.c == 2'd1) w = w + 64'(f.t) * 64'd256;
      else             w = w + (64'(f.im) % 64'd16384);
      return w[31:0];
   endfunction

   function automatic fs_t rand_fs();
      fs_t f;
      f.c  = 2'($urandom_range(0, 3));
      f.op = 4'($urandom);
      f.d  = 6'($urandom);
      f.s  = 6'($urandom);
      f.t  = 6'($urandom);
      f.im = 15'($urandom);
      return f;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_fs(input fs_t f, input logic last);
      cls = f.c; aluop = f.op; rd = f.d; rs = f.s; rt = f.t; imm = f.im;
      in_last = last; in_valid = 1'b1;
   endtask

   task automatic pulse_start(input logic vld, input logic [7:0] sa);
      start = 1'b1; start_addr_vld = vld; start_addr = sa;
      tick();
      start = 1'b0;
   endtask

   // Push every set in sess, wait for done, compare writes with exp_q.
   task automatic run_session(input string nm, input logic vld, input logic [7:0] sa,
                              input int max_gap);
      int to;
      logic [7:0] base;
      base = vld ? sa : 8'h00;
      cap_addr.delete(); cap_data.delete(); done_cnt = 0;
      pulse_start(vld, sa);
      foreach (sess[i]) begin
         if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
         drive_fs(sess[i], (i == sess.size() - 1));
         to = 0;
         while (!in_ready && to < 50) begin tick(); to++; end
         if (to >= 50) chk({nm, "_ready_timeout"}, 32'(to), 32'd0);
         tick();
         in_valid = 1'b0; in_last = 1'b0;
      end
      to = 0;
      while (!done && to < 60) begin tick(); to++; end
      chk({nm, "_done_seen"}, 32'(done), 32'd1);
      tick();
      chk({nm, "_done_one_cycle"}, 32'(done), 32'd0);
      chk({nm, "_busy_after"}, 32'(busy), 32'd0);
      chk({nm, "_done_count"}, 32'(done_cnt), 32'd1);
      chk({nm, "_write_count"}, 32'(cap_data.size()), 32'(exp_q.size()));
      foreach (exp_q[i]) begin
         if (i < cap_data.size()) begin
            chk($sformatf("%s_addr%0d", nm, i), 32'(cap_addr[i]), 32'(8'(base + 8'(i))));
            chk($sformatf("%s_data%0d", nm, i), cap_data[i], exp_q[i]);
         end
      end
      chk({nm, "_err"}, 32'(err), 32'(exp_err != 0));
      chk({nm, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
   endtask

   task automatic load_model_session(input int n);
      fs_t f;
      sess.delete(); exp_q.delete(); exp_err = 0;
      for (int i = 0; i < n; i++) begin
         f = rand_fs();
         sess.push_back(f);
         exp_q.push_back(model_word(f));
         if (model_bad(f)) exp_err++;
      end
   endtask

   vec_t vt[6];
   fs_t  f0;

   initial begin
      rst = 1'b1; start = 1'b0; start_addr_vld = 1'b0; start_addr = 8'h00;
      in_valid = 1'b0; in_last = 1'b0; cls = 2'd0; aluop = 4'd0;
      rd = 6'd0; rs = 6'd0; rt = 6'd0; imm = 15'd0;

      // Hand-derived vectors from the field layout.
      vt[0] = '{'{2'd1, 4'h3, 6'd5, 6'd7, 6'd63, 15'h0000}, 32'h4C51_FF00};
      vt[1] = '{'{2'd2, 4'h0, 6'd1, 6'd2, 6'd0, 15'h1FFF}, 32'h8010_9FFF};
      vt[2] = '{'{2'd0, 4'h1, 6'd0, 6'd3, 6'd0, 15'h0005}, 32'h0400_C005};
      vt[3] = '{'{2'd3, 4'h7, 6'd9, 6'd9, 6'd9, 15'h0123}, 32'h0000_0000};
`ifdef IMM_RANGE_CHECK_EN
      vt[4] = '{'{2'd2, 4'hF, 6'd63, 6'd63, 6'd0, 15'h4000}, 32'h0000_0000};
`else
      vt[4] = '{'{2'd2, 4'hF, 6'd63, 6'd63, 6'd0, 15'h4000}, 32'hBFFF_C000};
`endif
      vt[5] = '{'{2'd0, 4'h0, 6'd0, 6'd0, 6'd0, 15'h7FFF}, 32'h0000_3FFF};

      repeat (3) tick();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_im_we", 32'(im_we), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      chk("rst_im_addr", 32'(im_addr), 32'd0);
      chk("rst_im_wdata", im_wdata, 32'd0);
      rst = 1'b0;
      tick();

      // in_valid while IDLE is ignored.
      cap_addr.delete(); cap_data.delete();
      drive_fs(vt[0].f, 1'b1);
      repeat (3) tick();
      in_valid = 1'b0;
      chk("idle_in_ready", 32'(in_ready), 32'd0);
      chk("idle_no_write", 32'(cap_data.size()), 32'd0);
      chk("idle_err_cnt", 32'(err_cnt), 32'd0);

      // Latency and done timing; a start while busy is ignored.
      pulse_start(1'b1, 8'h10);
      chk("lat_ready", 32'(in_ready), 32'd1);
      drive_fs(vt[0].f, 1'b1);
      tick();
      in_valid = 1'b0; in_last = 1'b0;
      chk("lat_we_early", 32'(im_we), 32'd0);
      chk("lat_ready_drain", 32'(in_ready), 32'd0);
      start = 1'b1; start_addr_vld = 1'b1; start_addr = 8'h99;
      tick();
      start = 1'b0;
      chk("lat_we", 32'(im_we), 32'd1);
      chk("lat_addr", 32'(im_addr), 32'h10);
      chk("lat_data", im_wdata, 32'h4C51_FF00);
      chk("lat_done_early", 32'(done), 32'd0);
      tick();
      chk("lat_we_off", 32'(im_we), 32'd0);
      chk("lat_done", 32'(done), 32'd1);
      chk("lat_busy_done", 32'(busy), 32'd1);
      tick();
      chk("lat_done_off", 32'(done), 32'd0);
      chk("lat_busy_idle", 32'(busy), 32'd0);

      // Table session: vectors applied in order at a chosen base.
      sess.delete(); exp_q.delete(); exp_err = 0;
      for (int i = 0; i < 6; i++) begin
         sess.push_back(vt[i].f);
         exp_q.push_back(vt[i].exp_word);
         if (vt[i].exp_word == 32'h0) exp_err++;
      end
      run_session("table", 1'b1, 8'h20, 0);

      // Address wrap from FF.
      load_model_session(3);
      run_session("wrap", 1'b1, 8'hFF, 0);

      // Ten back-to-back sets with no gaps.
      load_model_session(10);
      run_session("burst10", 1'b1, 8'h30, 0);

      // Reset in the middle of a session.
      pulse_start(1'b1, 8'h40);
      f0 = vt[3].f; drive_fs(f0, 1'b0); tick();
      f0 = vt[0].f; drive_fs(f0, 1'b0); tick();
      f0 = vt[1].f; drive_fs(f0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      chk("mrst_im_we", 32'(im_we), 32'd0);
      chk("mrst_in_ready", 32'(in_ready), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_im_addr", 32'(im_addr), 32'd0);
      chk("mrst_err_cnt", 32'(err_cnt), 32'd0);
      tick();
      load_model_session(2);
      run_session("post_rst", 1'b0, 8'hAA, 0);

      // Randomised sessions against the reference model.
      for (int k = 0; k < 6; k++) begin
         load_model_session($urandom_range(1, 10));
         run_session($sformatf("rand%0d", k), 1'($urandom_range(0, 1)),
                     8'($urandom), 2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
